csd2bin_seq_arb: RTL and testbench

Shared, digit-serial converter from CSD (borrow-save) to two's complement, serving N requesters. It sits between the BKM iteration units that produce redundant CSD results and the binary consumers downstream. One requester is granted round-robin, and its 2W-bit operand is converted D digits per cycle with a registered carry. The W-bit result is returned with a valid/ready handshake, tagged with the requester index.

---
 rtl/csd2bin_pkg.sv | 7 +
 rtl/csd2bin_slice.sv | 21 ++
 rtl/csd2bin_seq_arb.sv | 91 +++++++++
 tb/tb_csd2bin_seq_arb.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csd2bin_pkg.sv
// csd2bin_pkg: shared FSM state type and requester-id width helper for csd2bin_seq_arb
package csd2bin_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_DONE} state_t;
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/csd2bin_slice.sv
// csd2bin_slice: combinational D-digit CSD to binary slice, y = x^d + ~x^s + cin rippled per digit
module csd2bin_slice #(
  parameter int D = 8
) (
  input  logic [2*D-1:0] x,
  input  logic           cin,
  output logic [D-1:0]   y,
  output logic           cout
);
  logic [D:0] c;
  always_comb begin
    c = '0;
    y = '0;
    c[0] = cin;
    for (int j = 0; j < D; j++) begin
      y[j] = x[2*j] ^ ~x[2*j+1] ^ c[j];
      c[j+1] = (x[2*j] & ~x[2*j+1]) | (c[j] & (x[2*j] | ~x[2*j+1]));
    end
  end
  assign cout = c[D];
endmodule

// File: rtl/csd2bin_seq_arb.sv
// csd2bin_seq_arb: round-robin shared digit-serial CSD to two's complement converter; out_ovf exists with CSD2BIN_SEQ_OVF_EN
module csd2bin_seq_arb
  import csd2bin_pkg::*;
#(
  parameter int W = 64,
  parameter int N = 2,
  parameter int D = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  input  logic [N*2*W-1:0]     req_x,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_y,
`ifdef CSD2BIN_SEQ_OVF_EN
  output logic                 out_ovf,
`endif
  output logic [id_w(N)-1:0]   out_id
);
  localparam int IW = id_w(N);
  localparam int S = W / D;
  localparam int CW = (S > 1) ? $clog2(S) : 1;
  state_t         state;
  logic [IW-1:0]  ptr;
  logic [IW-1:0]  gnt;
  logic           found;
  logic           carry;
  logic           cout;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] op;
  logic [D-1:0]   sy;
  logic [W+D-1:0] cat;
  always_comb begin
    found = 1'b0;
    gnt = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req_valid[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        gnt = IW'((int'(ptr) + k) % N);
      end
  end
  always_comb begin
    req_ready = '0;
    if (state == ST_IDLE && !rst && found) req_ready[gnt] = 1'b1;
  end
  csd2bin_slice #(.D(D)) u_slice (
    .x    (op[2*D-1:0]),
    .cin  (carry),
    .y    (sy),
    .cout (cout)
  );
  // new digits enter out_y from the MSB side so the last slice lands on top
  assign cat = {sy, out_y};
  assign out_valid = state == ST_DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ptr <= '0;
      carry <= 1'b1;
      cnt <= '0;
      op <= '0;
      out_y <= '0;
      out_id <= '0;
`ifdef CSD2BIN_SEQ_OVF_EN
      out_ovf <= 1'b0;
`endif
    end else if (state == ST_IDLE && found) begin
      op <= req_x[2*W*int'(gnt) +: 2*W];
      out_id <= gnt;
      carry <= 1'b1;
      cnt <= '0;
      ptr <= (gnt == IW'(N - 1)) ? '0 : gnt + 1'b1;
      state <= ST_CONV;
    end else if (state == ST_CONV) begin
      op <= op >> (2*D);
      out_y <= cat[W+D-1:D];
      carry <= cout;
      cnt <= cnt + 1'b1;
      if (cnt == CW'(S - 1)) begin
        state <= ST_DONE;
`ifdef CSD2BIN_SEQ_OVF_EN
        out_ovf <= sy[D-1] == cout;
`endif
      end
    end else if (state == ST_DONE && out_ready) begin
      state <= ST_IDLE;
    end
  end
endmodule

// File: tb/tb_csd2bin_seq_arb.sv
// tb_csd2bin_seq_arb: directed bench with a transaction-level model for csd2bin_seq_arb (W=8, D=4, N=2)
module tb_csd2bin_seq_arb;
  localparam int W = 8;
  localparam int N = 2;
  localparam int D = 4;
  localparam int S = W / D;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic out_ready = 1'b1;
  logic out_valid;
  logic ovf;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [N*2*W-1:0] req_x = '0;
  logic [W-1:0] out_y;
  logic [0:0] out_id;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  csd2bin_seq_arb #(.W(W), .N(N), .D(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
`ifdef CSD2BIN_SEQ_OVF_EN
    .out_ovf   (ovf),
`endif
    .out_id    (out_id)
  );
`ifndef CSD2BIN_SEQ_OVF_EN
  assign ovf = 1'b0;
`endif
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask
  function automatic logic [2*W-1:0] pack(input logic [W-1:0] xd, input logic [W-1:0] xs);
    logic [2*W-1:0] p;
    for (int j = 0; j < W; j++) begin
      p[2*j] = xd[j];
      p[2*j+1] = xs[j];
    end
    return p;
  endfunction
  function automatic int diff_of(input logic [2*W-1:0] x);
    int vd = 0;
    int vs = 0;
    for (int j = 0; j < W; j++) begin
      vd += int'(x[2*j]) << j;
      vs += int'(x[2*j+1]) << j;
    end
    return vd - vs;
  endfunction
  // transaction-level model: one job in flight, result due S+1 cycles after the grant
  bit busy = 0;
  int due = 0;
  int mptr = 0;
  logic [W-1:0] ey = '0;
  int eid = 0;
  logic eovf = 1'b0;
  always @(negedge clk) begin
    logic ev;
    logic [N-1:0] er;
    int g;
    int dv;
    bit any;
    ev = busy && cyc >= due;
    chk("out_valid", out_valid, ev);
    if (ev) begin
      chk("out_y", out_y, ey);
      chk("out_id", out_id, eid);
`ifdef CSD2BIN_SEQ_OVF_EN
      chk("out_ovf", ovf, eovf);
`endif
    end
    any = 0;
    g = 0;
    for (int k = N - 1; k >= 0; k--)
      if (req_valid[(mptr + k) % N]) begin
        any = 1;
        g = (mptr + k) % N;
      end
    er = '0;
    if (!rst && !busy && any) er[g] = 1'b1;
    chk("req_ready", req_ready, er);
    if (rst) begin
      busy = 0;
      mptr = 0;
    end else if (!busy && any) begin
      busy = 1;
      due = cyc + S + 1;
      dv = diff_of(req_x[2*W*g +: 2*W]);
      ey = dv[W-1:0];
      eid = g;
      eovf = dv > (2**(W-1) - 1) || dv < -(2**(W-1));
      mptr = (g + 1) % N;
    end else if (ev && out_ready) begin
      busy = 0;
    end
  end
  task automatic send(input int i, input logic [W-1:0] xd, input logic [W-1:0] xs, output int t);
    bit got = 0;
    t = -1;
    req_x[2*W*i +: 2*W] = pack(xd, xs);
    req_valid[i] = 1'b1;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        got = 1;
        t = cyc;
      end
    end
    chk("grant_wait", got, 1);
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
  endtask
  task automatic wait_valid();
    bit got = 0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      got = out_valid;
    end
    chk("valid_wait", got, 1);
  endtask
  task automatic expect_out(input string tag, input logic [W-1:0] y, input int id, input logic ov, input int t);
    wait_valid();
    chk({tag, "_y"}, out_y, y);
    chk({tag, "_id"}, out_id, id);
`ifdef CSD2BIN_SEQ_OVF_EN
    chk({tag, "_ovf"}, ovf, ov);
`endif
    if (t >= 0) chk({tag, "_latency"}, cyc - t, S + 1);
    @(posedge clk);
    #1;
  endtask
  initial begin
    int t;
    int nout;
    int ids[4];
    logic [N-1:0] upd;
    req_valid = 2'b11;
    repeat (2) @(negedge clk);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_out_ovf", ovf, 0);
    @(posedge clk);
    #1;
    req_valid = '0;
    rst = 1'b0;
    send(0, 8'h05, 8'h02, t);
    expect_out("single", 8'h03, 0, 1'b0, t);
    send(0, 8'h00, 8'h01, t);
    expect_out("neg1", 8'hFF, 0, 1'b0, t);
    send(0, 8'h00, 8'h80, t);
    expect_out("neg128", 8'h80, 0, 1'b0, t);
    send(1, 8'hFF, 8'h00, t);
    expect_out("ovf_pos", 8'hFF, 1, 1'b1, t);
    send(1, 8'h00, 8'hFF, t);
    expect_out("ovf_neg", 8'h01, 1, 1'b1, t);
    req_x = {pack(8'h21, 8'h01), pack(8'h10, 8'h30)};
    req_valid = 2'b11;
    nout = 0;
    for (int n = 0; n < 200 && nout < 4; n++) begin
      @(negedge clk);
      upd = req_ready;
      chk("ready_onehot", $countones(req_ready) <= 1, 1);
      if (out_valid) begin
        ids[nout] = int'(out_id);
        nout++;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
        if (upd[i]) req_x[2*W*i +: 2*W] = pack(8'(7 * n + i), 8'(3 * n));
      if (nout == 4) req_valid = '0;
    end
    chk("arb_count", nout, 4);
    chk("arb_id0", ids[0], 0);
    chk("arb_id1", ids[1], 1);
    chk("arb_id2", ids[2], 0);
    chk("arb_id3", ids[3], 1);
    out_ready = 1'b0;
    send(0, 8'h12, 8'h34, t);
    wait_valid();
    @(posedge clk);
    #1;
    req_x[2*W +: 2*W] = pack(8'h01, 8'h00);
    req_valid[1] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_y", out_y, 8'hDE);
      chk("bp_id", out_id, 0);
      chk("bp_ready", req_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", out_valid, 1);
    @(negedge clk);
    chk("bp_next_grant", req_ready, 2'b10);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    expect_out("bp_second", 8'h01, 1, 1'b0, -1);
    send(0, 8'h40, 8'h10, t);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("rst_abandon", out_valid, 0);
    end
    @(posedge clk);
    #1;
    req_x[2*W +: 2*W] = pack(8'h09, 8'h02);
    req_valid = 2'b11;
    @(negedge clk);
    chk("rst_ptr", req_ready, 2'b01);
    @(posedge clk);
    #1;
    req_valid = '0;
    expect_out("rst_redo", 8'h30, 0, 1'b0, -1);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
